// File: rtl/rr_arbiter_2pn.sv
// Round-robin arbiter over 2**N requesters with a registered one-hot grant held until release.
// Define RR_ARB_TIMEOUT_EN to force-release grants after MAX_HOLD cycles and pulse TIMEOUT.
module rr_arbiter_2pn #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [2**N-1:0]   REQ,
  input  logic              DONE,
  output logic [2**N-1:0]   GNT,
  output logic              GNT_VALID,
  output logic              TIMEOUT
);

  localparam int W = 2**N;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_2pn: MAX_HOLD must be in 1..255");
  end

  logic         state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] owner_q, owner_d;
  logic [W-1:0] gnt_q, gnt_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic         timeout_q, timeout_d;

  logic         sel_found;
  logic [N-1:0] sel_idx;
  logic [N-1:0] probe;
  logic         hold_limit;
  logic         release_now;

  // Priority search starting at ptr_q; the N-bit add wraps past 2**N-1 back to 0.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int i = 0; i < W; i++) begin
      probe = ptr_q + N'(i);
      if (!sel_found && REQ[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Held at zero while idle, so it starts from zero on every arbitration edge.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == STATE_IDLE) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != 8'hFF) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign hold_limit = (state_q == STATE_GRANT) && (hold_cnt_q == 8'(MAX_HOLD - 1));
`else
  assign hold_limit = 1'b0;
`endif

  assign release_now = DONE || !REQ[owner_q] || hold_limit;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (sel_found) begin
          gnt_d       = W'(1) << sel_idx;
          owner_d     = sel_idx;
          gnt_valid_d = 1'b1;
          state_d     = STATE_GRANT;
        end
      end
      STATE_GRANT: begin
        if (release_now) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = owner_q + N'(1);
          // A forced release still reports even when DONE arrives on the same cycle.
          timeout_d   = hold_limit;
          state_d     = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= STATE_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = gnt_valid_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_2pn.sv
// Scoreboard bench for rr_arbiter_2pn: an N=2 instance (MAX_HOLD=4) and an N=5 instance feeding an encoder.
module tb_rr_arbiter_2pn;

  typedef struct {
    logic [3:0] gnt;
    int         len;      // expected grant length in cycles, 0 = not checked
    logic       timeout;  // expected TIMEOUT on the release cycle
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req2;
  logic        done2;
  logic [3:0]  gnt2;
  logic        gv2;
  logic        to2;
  logic [31:0] req5;
  logic        done5;
  logic [31:0] gnt5;
  logic        gv5;
  logic        to5;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];
  int   enc_q[$];

  rr_arbiter_2pn #(.N(2), .MAX_HOLD(4)) dut2 (
    .CLK(clk), .RSTn(rst_n), .REQ(req2), .DONE(done2),
    .GNT(gnt2), .GNT_VALID(gv2), .TIMEOUT(to2)
  );

  rr_arbiter_2pn #(.N(5)) dut5 (
    .CLK(clk), .RSTn(rst_n), .REQ(req5), .DONE(done5),
    .GNT(gnt5), .GNT_VALID(gv5), .TIMEOUT(to5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream 2**N-to-N encoder: OR of the indices of set bits.
  function automatic int enc5(input logic [31:0] g);
    int r = 0;
    for (int i = 0; i < 32; i++) if (g[i]) r = r | i;
    return r;
  endfunction

  // Monitor for the N=2 instance: pops one expectation per grant.
  exp_t cur;
  bit   mon_active = 1'b0;
  int   mon_len    = 0;
  bit   mon_stable = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active && gv2) begin
      check("grant_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) cur = sb_q.pop_front();
      else cur = '{4'b0000, 0, 1'b0};
      check("grant_value", gnt2, cur.gnt);
      check("grant_onehot", 32'($onehot(gnt2)), 1);
      mon_active = 1'b1;
      mon_len    = 1;
      mon_stable = (to2 === 1'b0);
    end else if (mon_active && gv2) begin
      mon_len++;
      if (gnt2 !== cur.gnt || to2 !== 1'b0) mon_stable = 1'b0;
    end else if (mon_active && !gv2) begin
      check("grant_stable", 32'(mon_stable), 1);
      if (cur.len != 0) check("grant_length", mon_len, cur.len);
      check("release_timeout", to2, cur.timeout);
      check("release_gnt_zero", gnt2, 0);
      mon_active = 1'b0;
    end
  end

  // Monitor for the N=5 instance: encoder index on each new grant.
  bit prev_gv5 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_gv5 = 1'b0;
    end else begin
      if (gv5 && !prev_gv5) begin
        check("enc_expected", 32'(enc_q.size() != 0), 1);
        if (enc_q.size() != 0) check("enc_index", enc5(gnt5), enc_q.pop_front());
        check("enc_onehot", 32'($onehot(gnt5)), 1);
      end
      prev_gv5 = gv5;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req2  = '0;
    done2 = 1'b0;
    req5  = '0;
    done5 = 1'b0;
    step();
    step();
    check("reset_gnt", gnt2, 0);
    check("reset_valid", gv2, 0);
    check("reset_timeout", to2, 0);
    check("reset_gnt5", gnt5, 0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-grant clears the grant immediately.
    sb_q.push_back('{4'b0100, 0, 1'b0});
    req2 = 4'b0100;
    step();
    check("pre_reset_gnt", gnt2, 4'b0100);
    step();
    rst_n = 1'b0;
    #1;
    check("async_reset_gnt", gnt2, 0);
    check("async_reset_valid", gv2, 0);
    step();
    req2  = 4'b1111;
    rst_n = 1'b1;

    // Rotation with all requesters active: first grant shows PTR returned to 0.
    sb_q.push_back('{4'b0001, 1, 1'b0});
    sb_q.push_back('{4'b0010, 1, 1'b0});
    sb_q.push_back('{4'b0100, 1, 1'b0});
    sb_q.push_back('{4'b1000, 1, 1'b0});
    sb_q.push_back('{4'b0001, 1, 1'b0});
    for (int k = 0; k < 5; k++) begin
      step();
      done2 = 1'b1;
      step();
      done2 = 1'b0;
      check("rotation_gap", gnt2, 0);
    end

    // Wrap and skip: grant index 2 leaves PTR=3, then 0011 picks 0 then 1.
    sb_q.push_back('{4'b0100, 1, 1'b0});
    sb_q.push_back('{4'b0001, 1, 1'b0});
    sb_q.push_back('{4'b0010, 1, 1'b0});
    req2 = 4'b0100;
    step();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    req2  = 4'b0011;
    step();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    step();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    req2  = '0;

    // Owner drop with REQ[3] toggling mid-grant, then PTR=2 shows as grant to index 2.
    sb_q.push_back('{4'b0010, 3, 1'b0});
    sb_q.push_back('{4'b0100, 1, 1'b0});
    sb_q.push_back('{4'b1000, 1, 1'b0});
    req2 = 4'b0010;
    step();
    req2 = 4'b1010;
    step();
    check("toggle_req3_hi", gnt2, 4'b0010);
    req2 = 4'b0010;
    step();
    check("toggle_req3_lo", gnt2, 4'b0010);
    req2 = 4'b0000;
    step();
    check("owner_drop_gnt", gnt2, 0);
    check("owner_drop_valid", gv2, 0);
    req2 = 4'b1111;
    step();
    req2  = 4'b1011;
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    check("single_release_gap", gnt2, 0);
    step();
    check("single_release_next", gnt2, 4'b1000);
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    req2  = '0;

    // DONE in IDLE has no effect.
    done2 = 1'b1;
    step();
    step();
    check("done_idle_gnt", gnt2, 0);
    check("done_idle_valid", gv2, 0);
    done2 = 1'b0;

`ifdef RR_ARB_TIMEOUT_EN
    sb_q.push_back('{4'b0001, 4, 1'b1});
    sb_q.push_back('{4'b0001, 4, 1'b1});
    req2 = 4'b0001;
    step();
    repeat (3) step();
    check("hold_last_cycle", gnt2, 4'b0001);
    check("hold_no_pulse", to2, 0);
    step();
    check("timeout_pulse", to2, 1);
    check("timeout_gnt_clear", gnt2, 0);
    step();
    check("timeout_one_cycle", to2, 0);
    check("timeout_regrant", gnt2, 4'b0001);
    repeat (3) step();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    req2  = '0;
    check("timeout_over_done", to2, 1);
    step();
    check("timeout_over_done_end", to2, 0);
`else
    sb_q.push_back('{4'b0001, 20, 1'b0});
    req2 = 4'b0001;
    step();
    repeat (19) step();
    check("held_no_timeout_gnt", gnt2, 4'b0001);
    check("held_no_timeout_pulse", to2, 0);
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    req2  = '0;
    check("held_release_gnt", gnt2, 0);
    check("held_release_timeout", to2, 0);
`endif

    // Encoder chain on the N=5 instance: set PTR=1, then 0x8000_0001 yields 31 then 0.
    enc_q.push_back(0);
    enc_q.push_back(31);
    enc_q.push_back(0);
    req5 = 32'h0000_0001;
    step();
    done5 = 1'b1;
    step();
    done5 = 1'b0;
    req5  = 32'h8000_0001;
    step();
    check("enc_gnt31", gnt5, 32'h8000_0000);
    done5 = 1'b1;
    step();
    done5 = 1'b0;
    step();
    check("enc_gnt0", gnt5, 32'h0000_0001);
    done5 = 1'b1;
    step();
    done5 = 1'b0;
    req5  = '0;
    check("enc_timeout_quiet", to5, 0);

    repeat (3) step();
    check("sb_drained", sb_q.size(), 0);
    check("enc_drained", enc_q.size(), 0);
    check("monitor_idle", 32'(mon_active), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
